// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode decoder: frame layout, prefix bytes,
// prefix-tracking states and the key event record.
package ps2_pkg;

    localparam int FRAME_W   = 11;
    localparam int START_BIT = 0;
    localparam int PAR_BIT   = 9;
    localparam int STOP_BIT  = 10;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    // Start low, stop high, odd parity over data plus parity bit.
    function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
        return (f[START_BIT] == 1'b0) && (f[STOP_BIT] == 1'b1) && (^f[PAR_BIT:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small key-event FIFO with a registered head; a push into a full FIFO without a
// simultaneous pop is silently dropped (the caller counts it).
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  key_event_t push_data,
    input  logic       pop_ready,
    output logic       out_valid,
    output key_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    key_event_t       mem_reg [DEPTH];
    key_event_t       head_reg, head_next;
    logic             push_en, pop_en;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign head      = head_reg;

    assign pop_en  = out_valid && pop_ready;
    assign push_en = push && (!full || pop_en);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;
        if (push_en) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        // The head is the entry at the next read pointer; if that slot is being
        // written this cycle, take the incoming event. Otherwise hold the last value.
        if (count_next != '0) begin
            if (push_en && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = push_data;
            end else begin
                head_next = mem_reg[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Checks PS/2 frames, folds E0/F0 prefixes into key events and queues them;
// bad frames and FIFO overflows are tallied in saturating counters.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame,
    input  logic               frame_valid,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_code,
    output logic               out_ext,
    output logic               out_brk,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [ERR_W-1:0]   ovf_cnt
);

    state_t           state_reg, state_next;
    logic [ERR_W-1:0] err_cnt_reg, ovf_cnt_reg;
    logic             good, emit, err_inc, ovf_inc;
    logic             ext_flag, brk_flag, ext_next, brk_next;
    logic [7:0]       data_byte;
    key_event_t       ev, head;
    logic             fifo_full, fifo_empty;

    assign data_byte = frame[8:1];
    assign good      = frame_ok(frame);
    assign err_inc   = frame_valid && !good;
    assign ext_flag  = (state_reg == EXT) || (state_reg == EXT_BRK);
    assign brk_flag  = (state_reg == BRK) || (state_reg == EXT_BRK);

    // Prefixes only ever add flags; any other byte closes the event with the flags gathered.
    always_comb begin
        state_next = state_reg;
        emit       = 1'b0;
        ev         = '0;
        ext_next   = ext_flag;
        brk_next   = brk_flag;
        if (frame_valid) begin
            if (!good) begin
                state_next = IDLE;
            end else begin
                if (data_byte == PFX_EXT) begin
                    ext_next = 1'b1;
                end else if (data_byte == PFX_BRK) begin
                    brk_next = 1'b1;
                end else begin
                    emit     = 1'b1;
                    ev.ext   = ext_flag;
                    ev.brk   = brk_flag;
                    ev.code  = data_byte;
                    ext_next = 1'b0;
                    brk_next = 1'b0;
                end
                case ({ext_next, brk_next})
                    2'b10:   state_next = EXT;
                    2'b01:   state_next = BRK;
                    2'b11:   state_next = EXT_BRK;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    assign ovf_inc = emit && fifo_full && !(out_valid && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            err_cnt_reg <= '0;
            ovf_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (err_inc && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
            if (ovf_inc && (ovf_cnt_reg != '1)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (emit),
        .push_data (ev),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_code = head.code;
    assign out_ext  = head.ext;
    assign out_brk  = head.brk;
    assign err_cnt  = err_cnt_reg;
    assign ovf_cnt  = ovf_cnt_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder: framing, prefixes,
// error counting, FIFO overflow, full push/pop and asynchronous reset.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;
    localparam int ERR_W = 8;

    logic             clk;
    logic             rst_n;
    logic [10:0]      frame;
    logic             frame_valid;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_code;
    logic             out_ext;
    logic             out_brk;
    logic [ERR_W-1:0] err_cnt;
    logic [ERR_W-1:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    ps2_scancode_decoder #(
        .DEPTH (DEPTH),
        .ERR_W (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame       (frame),
        .frame_valid (frame_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_ext     (out_ext),
        .out_brk     (out_brk),
        .err_cnt     (err_cnt),
        .ovf_cnt     (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a frame; the parity bit makes data+parity odd unless bad_par is set.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                             input logic bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Drive one frame for one cycle; returns at the negedge after the push edge.
    task automatic send(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        @(negedge clk);
        frame       = mk_frame(d, bad_par, bad_stop);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        $display("frame data=%h bad_par=%0b bad_stop=%0b -> valid=%0b code=%h ext=%0b brk=%0b err=%0d ovf=%0d",
                 d, bad_par, bad_stop, out_valid, out_code, out_ext, out_brk, err_cnt, ovf_cnt);
    endtask

    // Check the head event then pop it.
    task automatic pop_check(input string name, input logic ext, input logic brk,
                             input logic [7:0] code);
        checks++;
        if (out_valid !== 1'b1 || out_code !== code || out_ext !== ext || out_brk !== brk) begin
            errors++;
            $display("FAIL %s: got valid=%0b ext=%0b brk=%0b code=%h, expected valid=1 ext=%0b brk=%0b code=%h",
                     name, out_valid, out_ext, out_brk, out_code, ext, brk, code);
        end else begin
            $display("pop %s: ext=%0b brk=%0b code=%h", name, out_ext, out_brk, out_code);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: out_valid=%0b, expected 0", name, out_valid);
        end
    endtask

    task automatic check_cnt(input string name, input logic [ERR_W-1:0] exp_err,
                             input logic [ERR_W-1:0] exp_ovf);
        checks++;
        if (err_cnt !== exp_err || ovf_cnt !== exp_ovf) begin
            errors++;
            $display("FAIL %s: err_cnt=%0d ovf_cnt=%0d, expected err_cnt=%0d ovf_cnt=%0d",
                     name, err_cnt, ovf_cnt, exp_err, exp_ovf);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_code !== 8'h00 || out_ext !== 1'b0 || out_brk !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b code=%h ext=%0b brk=%0b, expected all zero",
                     out_valid, out_code, out_ext, out_brk);
        end
        check_cnt("reset_counters", 8'd0, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        @(negedge clk);
        frame       = mk_frame(8'h1C, 1'b0, 1'b0);
        frame_valid = 1'b1;
        check_empty("no_bypass");
        @(negedge clk);
        frame_valid = 1'b0;
        pop_check("basic_1C", 1'b0, 1'b0, 8'h1C);
        check_empty("basic_drained");
    endtask

    task automatic test_prefix;
        send(8'hE0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        check_empty("prefix_no_event");
        send(8'h75, 1'b0, 1'b0);
        pop_check("ext_brk_75", 1'b1, 1'b1, 8'h75);
        check_empty("prefix_single_event");
        send(8'hF0, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 1'b0);
        send(8'hAA, 1'b0, 1'b0);
        pop_check("brk_AA", 1'b0, 1'b1, 8'hAA);
        send(8'hE0, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0);
        send(8'h6B, 1'b0, 1'b0);
        pop_check("ext_6B", 1'b1, 1'b0, 8'h6B);
    endtask

    task automatic test_errors;
        send(8'h1C, 1'b1, 1'b0);
        check_cnt("bad_parity", 8'd1, 8'd0);
        check_empty("bad_parity_no_event");
        send(8'hF0, 1'b0, 1'b1);
        send(8'h1C, 1'b0, 1'b0);
        check_cnt("bad_stop", 8'd2, 8'd0);
        pop_check("prefix_dropped_1C", 1'b0, 1'b0, 8'h1C);
    endtask

    task automatic test_overflow;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(8'h10 + 8'(i), 1'b0, 1'b0);
        end
        check_cnt("overflow", 8'd2, 8'd2);
        for (int i = 0; i < DEPTH; i++) begin
            pop_check($sformatf("ovf_pop%0d", i), 1'b0, 1'b0, 8'h10 + 8'(i));
        end
        check_empty("overflow_drained");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < DEPTH; i++) begin
            send(8'h20 + 8'(i), 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_code !== 8'h20 + 8'(k)) begin
                errors++;
                $display("FAIL full_pushpop%0d: valid=%0b code=%h, expected valid=1 code=%h",
                         k, out_valid, out_code, 8'h20 + 8'(k));
            end else begin
                $display("push+pop %0d: popped code=%h", k, out_code);
            end
            frame       = mk_frame(8'h20 + 8'(DEPTH + k), 1'b0, 1'b0);
            frame_valid = 1'b1;
            out_ready   = 1'b1;
        end
        @(negedge clk);
        frame_valid = 1'b0;
        out_ready   = 1'b0;
        check_cnt("full_pushpop_no_ovf", 8'd2, 8'd2);
        for (int i = 0; i < DEPTH; i++) begin
            pop_check($sformatf("wrap_pop%0d", i), 1'b0, 1'b0, 8'h23 + 8'(i));
        end
        check_empty("wrap_drained");
    endtask

    task automatic test_async_reset;
        send(8'hE0, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_code !== 8'h00 || err_cnt !== 8'd0 || ovf_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b code=%h err=%0d ovf=%0d, expected 0 00 0 0",
                     out_valid, out_code, err_cnt, ovf_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hE0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h6B, 1'b0, 1'b0);
        pop_check("after_reset_6B", 1'b0, 1'b0, 8'h6B);
        check_cnt("after_reset_counters", 8'd0, 8'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        frame       = '0;
        frame_valid = 1'b0;
        out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_prefix();
        test_errors();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
